// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default width, FSM states and counter sizing.
package div_pkg;

   localparam int XLEN_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } divState_e;

   function automatic int cntWidth(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

   localparam int CNT_W = cntWidth(XLEN_DEFAULT);

endpackage

// File: rtl/div64_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits, producing one quotient bit.
module div64_step
   import div_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] r_i,
   input  logic [XLEN-1:0] q_i,
   input  logic [XLEN-1:0] d_i,
   output logic [XLEN-1:0] r_o,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          fits;

   // The partial remainder stays below the divisor, so the restored value always fits in XLEN bits.
   always_comb begin
      shifted = {r_i, q_i[XLEN-1]};
      fits    = (shifted >= {1'b0, d_i});
      diff    = shifted - {1'b0, d_i};
      r_o     = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      q_o     = {q_i[XLEN-2:0], fits};
   end

endmodule

// File: rtl/div64_iter.sv
// Multi-cycle restoring divider with start/busy/done handshake and pipeline flush.
// Optional DIV_EARLY_OUT_EN skips the iteration loop for div-by-zero or divisor > dividend.
module div64_iter
   import div_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            is_signed,
   input  logic            flush,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CntW = cntWidth(XLEN);

   divState_e       state_q;
   logic [CntW-1:0] cnt_q;
   logic [XLEN-1:0] quoWork_q;
   logic [XLEN-1:0] remWork_q;
   logic [XLEN-1:0] den_q;
   logic [XLEN-1:0] dividendOrig_q;
   logic            negQ_q;
   logic            negR_q;
   logic            divZero_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] quotient_q;
   logic [XLEN-1:0] remainder_q;

   logic            negA_d;
   logic            negB_d;
   logic [XLEN-1:0] absA_d;
   logic [XLEN-1:0] absB_d;
   logic            earlyOut_d;
   logic [XLEN-1:0] quoStep_d;
   logic [XLEN-1:0] remStep_d;
   logic [XLEN-1:0] quoFix_d;
   logic [XLEN-1:0] remFix_d;

   div64_step #(
      .XLEN(XLEN)
   ) uStep (
      .r_i(remWork_q),
      .q_i(quoWork_q),
      .d_i(den_q),
      .r_o(remStep_d),
      .q_o(quoStep_d)
   );

   // Magnitudes of the incoming operands; the core only ever sees unsigned values.
   always_comb begin
      negA_d   = is_signed & dividend[XLEN-1];
      negB_d   = is_signed & divisor[XLEN-1];
      absA_d   = negA_d ? (~dividend + 1'b1) : dividend;
      absB_d   = negB_d ? (~divisor + 1'b1) : divisor;
      quoFix_d = negQ_q ? (~quoWork_q + 1'b1) : quoWork_q;
      remFix_d = negR_q ? (~remWork_q + 1'b1) : remWork_q;
`ifdef DIV_EARLY_OUT_EN
      earlyOut_d = (divisor == '0) || (absB_d > absA_d);
`else
      earlyOut_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         quoWork_q      <= '0;
         remWork_q      <= '0;
         den_q          <= '0;
         dividendOrig_q <= '0;
         negQ_q         <= 1'b0;
         negR_q         <= 1'b0;
         divZero_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         quotient_q     <= '0;
         remainder_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !flush) begin
                  dividendOrig_q <= dividend;
                  den_q          <= absB_d;
                  negQ_q         <= negA_d ^ negB_d;
                  negR_q         <= negA_d;
                  divZero_q      <= (divisor == '0);
                  cnt_q          <= '0;
                  busy_q         <= 1'b1;
                  if (earlyOut_d) begin
                     quoWork_q <= '0;
                     remWork_q <= absA_d;
                     state_q   <= FIX;
                  end else begin
                     quoWork_q <= absA_d;
                     remWork_q <= '0;
                     state_q   <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  quoWork_q <= quoStep_d;
                  remWork_q <= remStep_d;
                  cnt_q     <= cnt_q + 1'b1;
                  if (cnt_q == CntW'(XLEN - 1)) begin
                     state_q <= FIX;
                  end
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  // Division by zero reports all ones and the untouched dividend regardless of sign.
                  quotient_q  <= divZero_q ? '1 : quoFix_d;
                  remainder_q <= divZero_q ? dividendOrig_q : remFix_d;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_div64_iter.sv
// Self-checking bench for div64_iter: directed corner cases, handshake/flush/reset behaviour
// and randomized operands compared against plain-arithmetic signed/unsigned division.
module tb_div64_iter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic        flush;
   logic [63:0] dividend;
   logic [63:0] divisor;
   logic        busy;
   logic        done;
   logic [63:0] quotient;
   logic [63:0] remainder;

   int          total = 0;
   int          bad = 0;
   logic [63:0] lastQ = '0;
   logic [63:0] lastR = '0;

   div64_iter uDut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .is_signed(is_signed),
      .flush(flush),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void refDiv(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                  output logic [63:0] q, output logic [63:0] r);
      if (b == 64'd0) begin
         q = '1;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
         q = a;
         r = 64'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endfunction

   function automatic int expLatency(input logic [63:0] a, input logic [63:0] b, input logic sgn);
      logic [63:0] ma;
      logic [63:0] mb;
      ma = (sgn && a[63]) ? -a : a;
      mb = (sgn && b[63]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
      if (b == 64'd0 || mb > ma) return 2;
`else
      if (ma == mb) return 66;
`endif
      return 66;
   endfunction

   // Leaves the bench #1 after the edge that samples start, i.e. at the cycle-1 sample point.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sgn);
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      is_signed = sgn;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
   endtask

   task automatic runOp(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                        input int restartAt, input string tag);
      logic [63:0] eq;
      logic [63:0] er;
      int          expLat;
      int          lat;
      int          busyCnt;
      logic        busyAtDone;
      refDiv(a, b, sgn, eq, er);
      expLat     = expLatency(a, b, sgn);
      lat        = 0;
      busyCnt    = 0;
      busyAtDone = 1'b1;
      applyStimulus(a, b, sgn);
      for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
         if (cyc > 1) begin
            @(posedge clk);
            #1;
         end
         if (cyc == restartAt) begin
            start     = 1'b1;
            is_signed = ~sgn;
         end else if (cyc == restartAt + 1) begin
            start = 1'b0;
         end
         if (done) begin
            lat        = cyc;
            busyAtDone = busy;
         end else if (busy) begin
            busyCnt++;
         end
      end
      start = 1'b0;
      checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, " busyCycles"}, 64'(busyCnt), 64'(expLat - 1));
      checkOutput({tag, " busyAtDone"}, {63'd0, busyAtDone}, 64'd0);
      checkOutput({tag, " quotient"}, quotient, eq);
      checkOutput({tag, " remainder"}, remainder, er);
      @(posedge clk);
      #1;
      checkOutput({tag, " donePulse"}, {63'd0, done}, 64'd0);
      lastQ = eq;
      lastR = er;
   endtask

   initial begin
      int          doneSeen;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;

      rst_n     = 1'b0;
      start     = 1'b0;
      flush     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #12;
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset done", {63'd0, done}, 64'd0);
      checkOutput("reset quotient", quotient, 64'd0);
      checkOutput("reset remainder", remainder, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOp(64'd100, 64'd7, 1'b0, -1, "u100/7");
      checkOutput("u100/7 q const", quotient, 64'd14);
      checkOutput("u100/7 r const", remainder, 64'd2);
      runOp(-64'sd7, 64'd2, 1'b1, -1, "s-7/2");
      checkOutput("s-7/2 q const", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
      checkOutput("s-7/2 r const", remainder, 64'hFFFF_FFFF_FFFF_FFFF);
      runOp(64'd5, 64'd0, 1'b0, -1, "u5/0");
      runOp(64'd5, 64'd0, 1'b1, -1, "s5/0");
      runOp(-64'sd5, 64'd0, 1'b1, -1, "s-5/0");
      checkOutput("s-5/0 r const", remainder, 64'hFFFF_FFFF_FFFF_FFFB);
      runOp(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, "sOverflow");
      runOp(64'd3, 64'd10, 1'b0, -1, "u3/10");
      runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, -1, "uMax/1");
      runOp(64'd12345, 64'd678, 1'b0, 10, "restartIgnored");

      // Flush mid-CALC: no done pulse, previous results held.
      applyStimulus(64'd999_999, 64'd13, 1'b0);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush busy", {63'd0, busy}, 64'd0);
      doneSeen = 0;
      for (int i = 0; i < 80; i++) begin
         if (done) doneSeen++;
         @(posedge clk);
         #1;
      end
      checkOutput("flush noDone", 64'(doneSeen), 64'd0);
      checkOutput("flush quotient held", quotient, lastQ);
      checkOutput("flush remainder held", remainder, lastR);

      // Start together with flush in IDLE must be dropped.
      @(negedge clk);
      dividend = 64'd77;
      divisor  = 64'd5;
      start    = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      checkOutput("flushStart busy", {63'd0, busy}, 64'd0);
      doneSeen = 0;
      for (int i = 0; i < 80; i++) begin
         if (done || busy) doneSeen++;
         @(posedge clk);
         #1;
      end
      checkOutput("flushStart idle", 64'(doneSeen), 64'd0);

      runOp(64'd1000, 64'd33, 1'b0, -1, "afterFlush");

      // Asynchronous reset mid-CALC clears outputs without waiting for a clock edge.
      applyStimulus(64'd5000, 64'd7, 1'b0);
      repeat (29) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midReset busy", {63'd0, busy}, 64'd0);
      checkOutput("midReset done", {63'd0, done}, 64'd0);
      checkOutput("midReset quotient", quotient, 64'd0);
      checkOutput("midReset remainder", remainder, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 16; n++) begin
         rs = 1'($urandom_range(0, 1));
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0: rb = {$urandom, $urandom};
            1: rb = 64'($urandom_range(1, 1000));
            2: rb = -64'($urandom_range(1, 1000));
            3: rb = 64'($urandom);
            default: rb = 64'd0;
         endcase
         if (n % 3 == 0) ra = 64'($urandom_range(0, 50));
         runOp(ra, rb, rs, -1, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
